// File: rtl/pss8_tx_if.sv
// Word-in / bit-out bus of the parallel-to-serial transmitter.
// Word side: start/rdy handshake carrying datai. Serial side: sdo with framing flags.
// The transmitter connects via the slave modport; the word producer and link use master.
interface pss8_tx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] datai;
  logic             rdy;
  logic             sdo;
  logic             sfrm;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output datai,
    input  rdy,
    input  sdo,
    input  sfrm,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  datai,
    output rdy,
    output sdo,
    output sfrm,
    output busy,
    output done
  );
endinterface

// File: rtl/pss8_tx.sv
// Parallel-to-serial transmitter: WIDTH-bit words out on sdo, one bit per clk, with sfrm/done framing.
// Latency: first bit on sdo in the cycle after the accepting edge; back-to-back words have no gap.
// Backpressure: rdy drops while the one-entry holding register is full; start without rdy is ignored.
module pss8_tx #(
  parameter int   WIDTH     = 8,
  parameter int   LSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic      clk,
  input  logic      clr_n,
  pss8_tx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             sdo_q, sdo_d;
  logic             sfrm_q, sfrm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rdy;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shreg_nxt;

  // The bit currently on the wire always sits at the output end of shreg.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  // Handshake is driven from registers and reset only, never from start.
  assign rdy    = ~hold_v_q & clr_n;
  assign accept = bus.start & rdy;

  assign shreg_nxt = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);

  // Next-state and datapath: shift, park a word in hold, or start a new word.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    sdo_d     = sdo_q;
    sfrm_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_word = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          load_word = bus.datai;
        end
      end
      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          shreg_d = shreg_nxt;
          sdo_d   = first_bit(shreg_nxt);
          cnt_d   = cnt_q + CW'(1);
          done_d  = (cnt_q == CNT_PEN);
          if (accept) begin
            hold_d   = bus.datai;
            hold_v_d = 1'b1;
          end
        end else if (hold_v_q) begin
          // Held word wins; rdy is low here so no accept can collide with it.
          load      = 1'b1;
          load_word = hold_q;
          hold_v_d  = 1'b0;
        end else if (accept) begin
          // Word offered during the last bit bypasses hold to avoid a gap.
          load      = 1'b1;
          load_word = bus.datai;
        end else begin
          state_d = IDLE;
          sdo_d   = IDLE_BIT;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = SHIFT;
      shreg_d = load_word;
      sdo_d   = first_bit(load_word);
      sfrm_d  = 1'b1;
      busy_d  = 1'b1;
      cnt_d   = '0;
    end
  end

  // State register with synchronous active-low clear; any word in flight or held is dropped.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      sdo_q    <= IDLE_BIT;
      sfrm_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      sdo_q    <= sdo_d;
      sfrm_q   <= sfrm_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rdy  = rdy;
  assign bus.sdo  = sdo_q;
  assign bus.sfrm = sfrm_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pss8_tx.sv
// Testbench for pss8_tx: an LSB-first and an MSB-first instance share the same stimulus.
// A word/bit-position reference model predicts every output each cycle.
// Received words are rebuilt from the serial streams and compared with the words the model finished.
module tb_pss8_tx;

  localparam int W = 8;

  logic clk;
  logic clr_n;

  pss8_tx_if #(.WIDTH(W)) ifa ();
  pss8_tx_if #(.WIDTH(W)) ifb ();

  assign ifb.start = ifa.start;
  assign ifb.datai = ifa.datai;

  pss8_tx #(.WIDTH(W), .LSB_FIRST(1), .IDLE_BIT(1'b0)) dut_lsb (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifa)
  );

  pss8_tx #(.WIDTH(W), .LSB_FIRST(0), .IDLE_BIT(1'b0)) dut_msb (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the word on the wire, its bit position (-1 = idle) and the waiting words.
  int           m_pos = -1;
  logic [W-1:0] m_cur = '0;
  logic [W-1:0] m_pend[$];
  logic [W-1:0] m_done_words[$];

  // Words rebuilt from each DUT's serial output.
  logic [W-1:0] cap0, cap1;
  int           k0 = 0;
  logic [W-1:0] rx0[$];
  logic [W-1:0] rx1[$];

  // Per-edge model update, output comparison and stream capture.
  initial begin
    logic s, r, acc;
    logic [W-1:0] d;
    logic e_busy, e_sdo0, e_sdo1;
    forever begin
      @(posedge clk);
      s = ifa.start;
      d = ifa.datai;
      r = clr_n;
      acc = r && s && (m_pend.size() == 0);
      if (!r) begin
        m_pos = -1;
        m_pend.delete();
      end else if (m_pos < 0) begin
        if (acc) begin
          m_cur = d;
          m_pos = 0;
        end
      end else if (m_pos < W - 1) begin
        m_pos++;
        if (acc) m_pend.push_back(d);
      end else if (m_pend.size() > 0) begin
        m_cur = m_pend.pop_front();
        m_pos = 0;
      end else if (acc) begin
        m_cur = d;
        m_pos = 0;
      end else begin
        m_pos = -1;
      end
      if (m_pos == W - 1) m_done_words.push_back(m_cur);

      #1;
      e_busy = (m_pos >= 0);
      e_sdo0 = e_busy ? m_cur[m_pos] : 1'b0;
      e_sdo1 = e_busy ? m_cur[W-1-m_pos] : 1'b0;
      check("rdy_lsb",  ifa.rdy,  clr_n && (m_pend.size() == 0));
      check("rdy_msb",  ifb.rdy,  clr_n && (m_pend.size() == 0));
      check("sdo_lsb",  ifa.sdo,  e_sdo0);
      check("sdo_msb",  ifb.sdo,  e_sdo1);
      check("busy_lsb", ifa.busy, e_busy);
      check("busy_msb", ifb.busy, e_busy);
      check("sfrm_lsb", ifa.sfrm, m_pos == 0);
      check("sfrm_msb", ifb.sfrm, m_pos == 0);
      check("done_lsb", ifa.done, m_pos == W - 1);
      check("done_msb", ifb.done, m_pos == W - 1);

      if (ifa.busy === 1'b1) begin
        if (ifa.sfrm === 1'b1) k0 = 0;
        if (k0 < W) cap0[k0] = ifa.sdo;
        k0++;
        if (ifa.done === 1'b1) rx0.push_back(cap0);
      end
      if (ifb.busy === 1'b1) begin
        cap1 = {cap1[W-2:0], ifb.sdo};
        if (ifb.done === 1'b1) rx1.push_back(cap1);
      end
    end
  end

  // Offer a word and hold start until it is accepted (bounded); start drops just after the accepting edge.
  task automatic send(input logic [W-1:0] w);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.datai = w;
    forever begin
      ok = ifa.rdy && clr_n;
      @(posedge clk);
      if (ok || n >= 50) break;
      n++;
      @(negedge clk);
    end
    #1 ifa.start = 1'b0;
    check("send_accept", ok, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic compare_rx();
    check("rx_count_lsb", rx0.size(), m_done_words.size());
    check("rx_count_msb", rx1.size(), m_done_words.size());
    for (int i = 0; i < m_done_words.size(); i++) begin
      if (i < rx0.size()) check("rx_word_lsb", rx0[i], m_done_words[i]);
      if (i < rx1.size()) check("rx_word_msb", rx1[i], m_done_words[i]);
    end
    rx0.delete();
    rx1.delete();
    m_done_words.delete();
  endtask

  initial begin
    clr_n     = 1'b0;
    ifa.start = 1'b1;
    ifa.datai = 8'hAA;

    // Reset held two edges with start high.
    repeat (2) @(posedge clk);
    #2;
    check("rst_rdy",  ifa.rdy,  1'b0);
    check("rst_sdo",  ifa.sdo,  1'b0);
    check("rst_busy", ifa.busy, 1'b0);
    check("rst_done", ifa.done, 1'b0);
    @(negedge clk);
    clr_n     = 1'b1;
    ifa.start = 1'b0;
    #1 check("rel_rdy", ifa.rdy, 1'b1);
    idle(2);
    compare_rx();

    // Single word.
    send(8'hA5);
    idle(12);
    check("a5_lsb", (rx0.size() > 0) ? rx0[0] : 8'h00, 8'hA5);
    check("a5_msb", (rx1.size() > 0) ? rx1[0] : 8'h00, 8'hA5);
    compare_rx();

    // Second word parked in hold one cycle after the first.
    send(8'h3C);
    send(8'hC3);
    idle(20);
    check("pair_n",  rx0.size(), 2);
    check("pair_w0", (rx0.size() > 0) ? rx0[0] : 8'h00, 8'h3C);
    check("pair_w1", (rx0.size() > 1) ? rx0[1] : 8'h00, 8'hC3);
    compare_rx();

    // Next word offered only during the last bit: bypass load, no gap.
    send(8'h0F);
    repeat (7) @(posedge clk);
    send(8'hF0);
    idle(12);
    compare_rx();

    // start while hold is full is ignored.
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.datai = 8'hFF;
    repeat (3) @(posedge clk);
    #1 ifa.start = 1'b0;
    idle(25);
    check("ign_n", rx0.size(), 2);
    compare_rx();

    // Reset mid-word with a word held, then a clean word.
    send(8'h55);
    send(8'h99);
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    send(8'h81);
    idle(12);
    check("rst_mid_n", rx0.size(), 1);
    check("rst_mid_w", (rx0.size() > 0) ? rx0[0] : 8'h00, 8'h81);
    compare_rx();

    // MSB-first ordering of a single low bit.
    send(8'h01);
    idle(12);
    check("msb01", (rx1.size() > 0) ? rx1[0] : 8'h00, 8'h01);
    compare_rx();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      ifa.start = ($urandom_range(0, 3) != 0);
      ifa.datai = W'($urandom);
      clr_n     = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk);
    ifa.start = 1'b0;
    clr_n     = 1'b1;
    idle(25);
    compare_rx();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
